// File: rtl/alu_pkg.sv
// Shared definitions for the X-Makina ALU and the multi-cycle multiply/divide
// unit: MDU op codes, the {V,N,Z,C} status bit indices, the MDU sequencer
// states and small op-decoding helpers.
package alu_pkg;

  // MDU op codes; 4-7 are reserved.
  typedef enum logic [2:0] {
    OP_MULU = 3'd0,
    OP_MULS = 3'd1,
    OP_DIVU = 3'd2,
    OP_DIVS = 3'd3
  } mdu_op_e;

  // Bit positions inside the 4-bit status word {V,N,Z,C}.
  typedef enum logic [1:0] {
    STAT_C = 2'd0,
    STAT_Z = 2'd1,
    STAT_N = 2'd2,
    STAT_V = 2'd3
  } stat_idx_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIVU) || (op == OP_DIVS);
  endfunction

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// One combinational iteration of the MDU datapath.
//   div     : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in  : 2*WORD accumulator before the step
//             multiply: {partial product high, remaining multiplier bits}
//             divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd    : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out : accumulator after the step
module mdu_iter #(
  parameter int WORD = 16
) (
  input  logic                div,
  input  logic [2*WORD-1:0]   acc_in,
  input  logic [WORD-1:0]     opnd,
  output logic [2*WORD-1:0]   acc_out
);

  logic [WORD:0] mul_sum;
  logic [WORD:0] div_shift;
  logic [WORD:0] div_trial;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    acc_out = acc_in;

    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    mul_sum = {1'b0, acc_in[2*WORD-1:WORD]}
            + {1'b0, (acc_in[0] ? opnd : {WORD{1'b0}})};

    // Divide: shift the next dividend bit into the remainder and try to
    // subtract. Bit WORD of the trial is the borrow: set means restore.
    div_shift = acc_in[2*WORD-1:WORD-1];
    div_trial = div_shift - {1'b0, opnd};

    if (div) begin
      if (!div_trial[WORD]) begin
        acc_out = {div_trial[WORD-1:0], acc_in[WORD-2:0], 1'b1};
      end else begin
        acc_out = {div_shift[WORD-1:0], acc_in[WORD-2:0], 1'b0};
      end
    end else begin
      acc_out = {mul_sum, acc_in[WORD-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit beside the combinational ALU.
// Iterative shift-add multiply (WORD x WORD -> 2*WORD) and restoring divide
// (quotient + remainder, truncating toward zero), signed and unsigned.
// WORD must be even and >= 4.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, sampled only while busy is low
//   flush             synchronous abort back to IDLE, beats start
//   op                0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4-7 reserved
//   opA, opB          multiplicand/dividend, multiplier/divisor
//   busy              high whenever the sequencer is not IDLE
//   done              one-cycle pulse when results have been written
//   result_lo/hi      product low/high word, or quotient/remainder
//   status            {V,N,Z,C}
module mdu_seq
  import alu_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] opA,
  input  logic [WORD-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] result_lo,
  output logic [WORD-1:0] result_hi,
  output logic [3:0]      status
);

  localparam int CNT_W = $clog2(WORD) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD - 1);
  localparam logic [WORD-1:0]  MOST_NEG  = {1'b1, {(WORD-1){1'b0}}};

  mdu_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [WORD-1:0]   a_q, b_q;
  logic [WORD-1:0]   opnd_q;
  logic [2*WORD-1:0] acc, acc_step;
  logic              neg_q;   // product / quotient must be negated
  logic              rneg_q;  // remainder must be negated (dividend sign)

  logic              is_div_op, is_signed, is_rsvd, div_zero, skip;
  logic              a_neg, b_neg;
  logic [WORD-1:0]   a_mag, b_mag;
  logic              accept;

  logic [2*WORD-1:0] prod;
  logic [WORD-1:0]   quo, rem;
  logic [WORD-1:0]   lo_n, hi_n;
  logic [3:0]        stat_n;

  // Operation decode from the latched request.
  assign is_div_op = op_is_div(op_q);
  assign is_rsvd   = op_is_reserved(op_q);
  assign is_signed = op_q[0];
  assign div_zero  = is_div_op && (b_q == '0);
  // Divide-by-zero and reserved ops skip the iterations entirely.
  assign skip      = is_rsvd || div_zero;

  assign a_neg = is_signed && a_q[WORD-1];
  assign b_neg = is_signed && b_q[WORD-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  assign accept = (state == IDLE) && start && !flush;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mdu_iter #(.WORD(WORD)) u_iter (
    .div     (is_div_op),
    .acc_in  (acc),
    .opnd    (opnd_q),
    .acc_out (acc_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic. Degenerate ops pass through RUN for a single cycle
  // without iterating, which gives them a fixed four-edge latency.
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = PREP;
        PREP:    state_n = RUN;
        RUN:     if (skip || (cnt == LAST_ITER)) state_n = FIX;
        FIX:     state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Sign correction and status formation, consumed in FIX.
  always_comb begin
    prod   = neg_q  ? -acc : acc;
    quo    = neg_q  ? -acc[WORD-1:0] : acc[WORD-1:0];
    rem    = rneg_q ? -acc[2*WORD-1:WORD] : acc[2*WORD-1:WORD];
    lo_n   = '0;
    hi_n   = '0;
    stat_n = '0;
    if (is_rsvd) begin
      stat_n[STAT_V] = 1'b1;
    end else if (!is_div_op) begin
      lo_n           = prod[WORD-1:0];
      hi_n           = prod[2*WORD-1:WORD];
      stat_n[STAT_Z] = (prod == '0);
      stat_n[STAT_N] = hi_n[WORD-1];
      if (is_signed) stat_n[STAT_V] = (hi_n != {WORD{lo_n[WORD-1]}});
      else           stat_n[STAT_C] = (hi_n != '0);
    end else if (div_zero) begin
      lo_n           = '1;
      hi_n           = a_q;
      stat_n[STAT_N] = 1'b1;
      stat_n[STAT_V] = 1'b1;
    end else begin
      lo_n           = quo;
      hi_n           = rem;
      stat_n[STAT_Z] = (quo == '0);
      stat_n[STAT_N] = quo[WORD-1];
      // Only most-negative / -1 overflows; the magnitude path already yields
      // quotient = most-negative and remainder = 0 for it.
      stat_n[STAT_V] = is_signed && (a_q == MOST_NEG) && (b_q == '1);
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      status    <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= opA;
        b_q  <= opB;
      end
      if (state == PREP) begin
        // Multiply keeps the multiplier in the low half and adds the
        // multiplicand; divide shifts the dividend out of the low half.
        opnd_q <= is_div_op ? b_mag : a_mag;
        acc    <= {{WORD{1'b0}}, (is_div_op ? a_mag : b_mag)};
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt    <= '0;
      end
      if ((state == RUN) && !skip && !flush) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == FIX) && !flush) begin
        result_lo <= lo_n;
        result_hi <= hi_n;
        status    <= stat_n;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (WORD = 16): a table of directed vectors
// with hand-computed results, status and latency, plus hand-written
// sequences for start-while-busy, flush and mid-operation reset.
module tb_mdu_seq;

  localparam int WORD = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [WORD-1:0] opA, opB;
  logic            busy, done;
  logic [WORD-1:0] result_lo, result_hi;
  logic [3:0]      status;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  st;   // {V,N,Z,C}
    int          lat;  // edge after which done is high
  } vec_t;

  vec_t vecs[$];

  mdu_seq #(.WORD(WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .status    (status)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a request so that the next rising edge (edge 1) samples it;
  // returns at the falling edge after edge 1 with start dropped.
  task automatic start_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int n;
    bit busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    start_op(v.op, v.a, v.b);
    n = 1;
    while (n <= 40) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({v.name, "_latency"}, lat, v.lat);
    check({v.name, "_busy"}, 32'(busy_ok), 32'd1);
    check({v.name, "_lo"}, v.lo, result_lo);
    check({v.name, "_hi"}, result_hi, v.hi);
    check({v.name, "_status"}, status, v.st);
    @(posedge clk);
    @(negedge clk);
    check({v.name, "_idle_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int dcnt;
    int first;

    vecs.push_back('{"mulu_max",   3'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0101, 19});
    vecs.push_back('{"muls_neg",   3'd1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 4'b0100, 19});
    vecs.push_back('{"muls_ovf",   3'd1, 16'h4000, 16'h0004, 16'h0000, 16'h0001, 4'b1000, 19});
    vecs.push_back('{"divs_neg",   3'd3, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 4'b0100, 19});
    vecs.push_back('{"divs_ovf",   3'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 4'b1100, 19});
    vecs.push_back('{"divu_zero",  3'd2, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 4'b1100, 4});
    vecs.push_back('{"reserved5",  3'd5, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b1000, 4});
    vecs.push_back('{"mulu_zero",  3'd0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0010, 19});
    vecs.push_back('{"divu_basic", 3'd2, 16'h1234, 16'h0010, 16'h0123, 16'h0004, 4'b0000, 19});
    vecs.push_back('{"divu_small", 3'd2, 16'h0005, 16'h0007, 16'h0000, 16'h0005, 4'b0010, 19});
    vecs.push_back('{"divs_negb",  3'd3, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 4'b0100, 19});
    vecs.push_back('{"muls_minsq", 3'd1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 4'b1000, 19});
    vecs.push_back('{"divs_zero",  3'd3, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 4'b1100, 4});
    vecs.push_back('{"mulu_noc",   3'd0, 16'h00FF, 16'h0100, 16'hFF00, 16'h0000, 4'b0000, 19});

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    opA   = '0;
    opB   = '0;
    #12;
    check("reset_outputs", {busy, done, result_lo, result_hi, status}, '0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start at edge 5 of a running MULU, and again during the DONE cycle:
    // both requests must be ignored.
    start_op(3'd0, 16'h0003, 16'h0007);
    dcnt  = 0;
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        dcnt++;
        if (first < 0) first = n;
      end
      if (n == 20) check("busy_start_in_done_ignored", busy, 1'b0);
      if (n == 4) begin
        start = 1'b1; op = 3'd2; opA = 16'hFFFF; opB = 16'h0001;
      end else if (n == 19) begin
        start = 1'b1; op = 3'd0; opA = 16'h0002; opB = 16'h0002;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_start_latency", first, 19);
    check("busy_start_done_count", dcnt, 1);
    check("busy_start_lo", result_lo, 16'h0015);
    check("busy_start_hi", result_hi, 16'h0000);
    check("busy_start_status", status, 4'b0000);

    // flush during a DIVU: IDLE after edge 9, no done, results untouched.
    start_op(3'd2, 16'h1234, 16'h0010);
    dcnt = 0;
    for (int n = 1; n <= 30; n++) begin
      if (done) dcnt++;
      if (n == 8) check("flush_busy_before", busy, 1'b1);
      if (n == 9) check("flush_idle_edge9", busy, 1'b0);
      flush = (n == 8);
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b0;
    check("flush_no_done", dcnt, 0);
    check("flush_results_kept", {result_lo, result_hi, status}, {16'h0015, 16'h0000, 4'b0000});
    run_vec(vecs[8]);

    // Reset mid-RUN: outputs return to zero without waiting for a clock.
    run_vec(vecs[0]);
    start_op(3'd0, 16'hFFFF, 16'hFFFF);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_run_outputs", {busy, done, result_lo, result_hi, status}, '0);
    @(negedge clk);
    check("rst_held_outputs", {busy, done, result_lo, result_hi, status}, '0);
    rst = 1'b0;
    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
